// File: rtl/grad_vote_accumulator_pkg.sv
// Shared definitions for the gradient vote accumulator (package bitnet_pkg).
// Optional popcount output is controlled by macro GRAD_VOTE_STATS_EN.
package bitnet_pkg;

  // Accumulator controller states.
  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  localparam int DEF_W_SIZE      = 1024;
  localparam int DEF_CNT_WIDTH   = 4;
  localparam int DEF_BATCH_WIDTH = 16;

endpackage

// File: rtl/grad_vote_accumulator_if.sv
// Gradient input and flip-mask output handshakes of the vote accumulator.
// flip_count_out exists only when GRAD_VOTE_STATS_EN is defined.
interface grad_vote_accumulator_if #(
  parameter int W_SIZE = 1024
);
  localparam int FC_W = $clog2(W_SIZE + 1);

  logic              grad_valid_in;
  logic              grad_ready_out;
  logic [W_SIZE-1:0] grad_in;
  logic              flip_valid_out;
  logic              flip_ready_in;
  logic [W_SIZE-1:0] flip_mask_out;
  logic              batch_done_out;
`ifdef GRAD_VOTE_STATS_EN
  logic [FC_W-1:0]   flip_count_out;
`endif

  // Accumulator side.
  modport slave (
    input  grad_valid_in, grad_in, flip_ready_in,
    output grad_ready_out, flip_valid_out, flip_mask_out, batch_done_out
`ifdef GRAD_VOTE_STATS_EN
    , output flip_count_out
`endif
  );

  // Upstream gradient source / downstream weight-update side.
  modport master (
    output grad_valid_in, grad_in, flip_ready_in,
    input  grad_ready_out, flip_valid_out, flip_mask_out, batch_done_out
`ifdef GRAD_VOTE_STATS_EN
    , input flip_count_out
`endif
  );

endinterface

// File: rtl/grad_vote_accumulator_vote_counter.sv
// One saturating vote counter. hit reports whether the value the counter is
// about to take (including this cycle's vote) meets the threshold, so the
// last sample of a batch is counted in the mask decision on the same edge.
module vote_counter #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 inc,
  input  logic [CNT_WIDTH-1:0] threshold,
  output logic                 hit
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_next;

  // Increment unless already saturated.
  always_comb begin
    count_next = count;
    if (inc && (count != CNT_MAX)) count_next = count + 1'b1;
  end

  assign hit = (count_next >= threshold);

  // Counter register; clear wins over an increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clear) count <= '0;
    else            count <= count_next;
  end

endmodule

// File: rtl/grad_vote_accumulator.sv
// Gradient vote accumulator: counts per-weight flip votes over a batch and
// hands the thresholded flip mask downstream over a valid/ready handshake.
// Define GRAD_VOTE_STATS_EN to add flip_count_out (popcount of the mask).
//
// state | meaning
// ACCUM | accepting gradients, counting votes
// EMIT  | mask presented, waiting for downstream ready
module grad_vote_accumulator
  import bitnet_pkg::*;
#(
  parameter int W_SIZE      = DEF_W_SIZE,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int BATCH_WIDTH = DEF_BATCH_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   clear_in,
  input  logic [BATCH_WIDTH-1:0] batch_size_in,
  input  logic [CNT_WIDTH-1:0]   threshold_in,
  grad_vote_accumulator_if.slave bus
);
  localparam int FC_W = $clog2(W_SIZE + 1);

  state_t                 state;
  logic [BATCH_WIDTH-1:0] sample_cnt;
  logic [BATCH_WIDTH-1:0] batch_size_q;
  logic [CNT_WIDTH-1:0]   threshold_q;
  logic                   grad_ready;
  logic                   flip_valid;
  logic [W_SIZE-1:0]      flip_mask;
  logic                   batch_done;

  logic                   transfer;
  logic                   handshake;
  logic                   first_sample;
  logic [BATCH_WIDTH-1:0] batch_size_eff;
  logic [BATCH_WIDTH-1:0] last_idx;
  logic                   last_sample;
  logic [CNT_WIDTH-1:0]   threshold_eff;
  logic                   cnt_clear;
  logic [W_SIZE-1:0]      hit;

  assign transfer  = bus.grad_valid_in & grad_ready;
  assign handshake = flip_valid & bus.flip_ready_in;

  // On the first sample the configuration registers are still being loaded,
  // so the live inputs stand in for them (matters for single-sample batches).
  assign first_sample   = (sample_cnt == '0);
  assign batch_size_eff = first_sample ? batch_size_in : batch_size_q;
  assign threshold_eff  = first_sample ? threshold_in  : threshold_q;
  assign last_idx       = (batch_size_eff == '0) ? '0 : batch_size_eff - 1'b1;
  assign last_sample    = transfer && (sample_cnt == last_idx);

  assign cnt_clear = clear_in | handshake;

  // Per-weight vote counters.
  for (genvar i = 0; i < W_SIZE; i++) begin : g_cnt
    vote_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_vote_counter (
      .clk       (clk_in),
      .rst_n     (rst_n_in),
      .clear     (cnt_clear),
      .inc       (transfer & bus.grad_in[i]),
      .threshold (threshold_eff),
      .hit       (hit[i])
    );
  end

`ifdef GRAD_VOTE_STATS_EN
  logic [FC_W-1:0] pop;
  logic [FC_W-1:0] flip_count;

  // Popcount of the mask about to be registered.
  always_comb begin
    pop = '0;
    for (int i = 0; i < W_SIZE; i++) pop = pop + FC_W'(hit[i]);
  end

  // Flip count register, loaded alongside the mask.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                             flip_count <= '0;
    else if (clear_in)                         flip_count <= '0;
    else if (state == ACCUM && last_sample)    flip_count <= pop;
  end

  assign bus.flip_count_out = flip_count;
`endif

  // Controller FSM with registered handshake outputs and mask.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ACCUM;
      sample_cnt   <= '0;
      batch_size_q <= '0;
      threshold_q  <= '0;
      grad_ready   <= 1'b1;
      flip_valid   <= 1'b0;
      flip_mask    <= '0;
      batch_done   <= 1'b0;
    end else if (clear_in) begin
      state      <= ACCUM;
      sample_cnt <= '0;
      grad_ready <= 1'b1;
      flip_valid <= 1'b0;
      flip_mask  <= '0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        ACCUM: begin
          if (transfer) begin
            if (first_sample) begin
              batch_size_q <= batch_size_in;
              threshold_q  <= threshold_in;
            end
            if (last_sample) begin
              flip_mask  <= hit;
              sample_cnt <= '0;
              state      <= EMIT;
              grad_ready <= 1'b0;
              flip_valid <= 1'b1;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (handshake) begin
            state      <= ACCUM;
            grad_ready <= 1'b1;
            flip_valid <= 1'b0;
            batch_done <= 1'b1;
          end
        end
        default: begin
          state      <= ACCUM;
          grad_ready <= 1'b1;
          flip_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grad_ready_out = grad_ready;
  assign bus.flip_valid_out = flip_valid;
  assign bus.flip_mask_out  = flip_mask;
  assign bus.batch_done_out = batch_done;

endmodule
